// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: packet FIFO feeding a 10-bit serial framer.
// Line idles high; each frame is start(0), 10 payload bits MSB first, stop(1).
`default_nettype none

module mtm_alu_serializer #(
  parameter int DEPTH    = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] packet,
  input  logic       data_valid,
  output logic       in_ready,
  output logic       sout,
  output logic       busy,
  output logic       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [9:0]    sreg, sreg_nx;
  logic [3:0]    bitcnt, bitcnt_nx;
  logic [3:0]    gapcnt, gapcnt_nx;
  logic          sout_nx;
  logic          push, pop, launch, nonempty;

  assign nonempty = (count != '0);
  assign in_ready = (count != FULL);
  assign push     = data_valid && in_ready;
  assign busy     = (state != IDLE) || nonempty;

  always_comb begin
    state_nx  = state;
    sreg_nx   = sreg;
    bitcnt_nx = bitcnt;
    gapcnt_nx = gapcnt;
    sout_nx   = sout;
    launch    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        sout_nx = 1'b1;
        launch  = nonempty;
      end
      START: begin
        sout_nx   = sreg[9];
        sreg_nx   = {sreg[8:0], 1'b0};
        bitcnt_nx = 4'd1;
        state_nx  = DATA;
      end
      DATA: begin
        if (bitcnt == 4'd10) begin
          sout_nx   = 1'b1;
          bitcnt_nx = 4'd0;
          state_nx  = STOP;
        end else begin
          sout_nx   = sreg[9];
          sreg_nx   = {sreg[8:0], 1'b0};
          bitcnt_nx = bitcnt + 4'd1;
        end
      end
      STOP: begin
        sout_nx = 1'b1;
        if (IDLE_GAP > 0) begin
          gapcnt_nx = GAP_LOAD;
          state_nx  = GAP;
        end else begin
          launch   = nonempty;
          state_nx = IDLE;
        end
      end
      GAP: begin
        sout_nx = 1'b1;
        if (gapcnt != 4'd0) begin
          gapcnt_nx = gapcnt - 4'd1;
        end else begin
          launch   = nonempty;
          state_nx = IDLE;
        end
      end
      default: begin
        sout_nx  = 1'b1;
        state_nx = IDLE;
      end
    endcase
    // Pop only from the registered head: a same-edge write is never bypassed.
    if (launch) begin
      pop      = 1'b1;
      sreg_nx  = mem[rptr];
      sout_nx  = 1'b0;
      state_nx = START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      sreg     <= '0;
      bitcnt   <= '0;
      gapcnt   <= '0;
      sout     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      sreg     <= sreg_nx;
      bitcnt   <= bitcnt_nx;
      gapcnt   <= gapcnt_nx;
      sout     <= sout_nx;
      overflow <= data_valid && !in_ready;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= packet;
  end

endmodule

`default_nettype wire

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench: two serializer instances (no gap / 3-cycle gap) decoded by a line monitor.
`default_nettype none

module tb_mtm_alu_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pkt_a, pkt_b;
  logic       dv_a, dv_b;
  logic       in_ready_a, sout_a, busy_a, overflow_a;
  logic       in_ready_b, sout_b, busy_b, overflow_b;
  logic [1:0] sout_w;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         frames = 0;
  logic [9:0] exp_q[$];
  int         starts_q[$];

  int         mst[2];
  int         mcnt[2];
  logic [9:0] msh[2];

  logic [9:0] burst[5] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h001};
  logic [11:0] seq = 12'b010110001011;

  mtm_alu_serializer #(.DEPTH(4), .IDLE_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .packet(pkt_a), .data_valid(dv_a),
    .in_ready(in_ready_a), .sout(sout_a), .busy(busy_a), .overflow(overflow_a)
  );

  mtm_alu_serializer #(.DEPTH(4), .IDLE_GAP(3)) dut_b (
    .clk(clk), .rst(rst), .packet(pkt_b), .data_valid(dv_b),
    .in_ready(in_ready_b), .sout(sout_b), .busy(busy_b), .overflow(overflow_b)
  );

  assign sout_w = {sout_b, sout_a};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int limit);
    int n = 0;
    while (frames < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_count", frames, target);
  endtask

  // Line receiver: decodes frames on both serial lines and checks them against the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mst[d] = 0;
      end else begin
        case (mst[d])
          0: if (sout_w[d] == 1'b0) begin
               mst[d]  = 1;
               mcnt[d] = 0;
               starts_q.push_back(cyc);
             end
          1: begin
               msh[d] = {msh[d][8:0], sout_w[d]};
               mcnt[d]++;
               if (mcnt[d] == 10) mst[d] = 2;
             end
          default: begin
               check_eq("stop_bit", 32'(sout_w[d]), 32'd1);
               if (exp_q.size() > 0)
                 check_eq("rx_packet", 32'(msh[d]), 32'(exp_q.pop_front()));
               else
                 check_eq("rx_unexpected", 32'(msh[d]), 32'hFFFF_FFFF);
               frames++;
               mst[d] = 0;
             end
        endcase
      end
    end
  end

  initial begin
    int w;
    int base;
    rst = 1'b1; dv_a = 1'b0; dv_b = 1'b0; pkt_a = '0; pkt_b = '0;
    tick(); tick();
    check_eq("rst_sout",     32'(sout_a),     32'd1);
    check_eq("rst_busy",     32'(busy_a),     32'd0);
    check_eq("rst_in_ready", 32'(in_ready_a), 32'd1);
    check_eq("rst_overflow", 32'(overflow_a), 32'd0);
    check_eq("rst_sout_b",   32'(sout_b),     32'd1);
    check_eq("rst_busy_b",   32'(busy_b),     32'd0);
    #2 rst = 1'b0;

    // Idle line with no traffic
    repeat (20) begin
      tick();
      check_eq("idle_sout",     32'(sout_a),     32'd1);
      check_eq("idle_busy",     32'(busy_a),     32'd0);
      check_eq("idle_in_ready", 32'(in_ready_a), 32'd1);
      check_eq("idle_overflow", 32'(overflow_a | overflow_b), 32'd0);
    end

    // Single packet, exact line waveform
    starts_q.delete();
    base = frames;
    exp_q.push_back(10'h2C5);
    pkt_a = 10'h2C5; dv_a = 1'b1;
    tick();
    w = cyc;
    dv_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("single_sout", 32'(sout_a), 32'(seq[11-i]));
      if (i == 11) check_eq("busy_during_stop", 32'(busy_a), 32'd1);
    end
    tick();
    check_eq("busy_after_stop", 32'(busy_a), 32'd0);
    check_eq("sout_after_stop", 32'(sout_a), 32'd1);
    wait_frames(base + 1, 50);
    check_eq("start_latency", (starts_q.size() > 0) ? starts_q[0] - w : -1, 1);

    // Five consecutive writes into DEPTH=4: head popped before the fifth
    repeat (3) tick();
    starts_q.delete();
    base = frames;
    for (int i = 0; i < 5; i++) begin
      pkt_a = burst[i]; dv_a = 1'b1;
      check_eq("burst_in_ready", 32'(in_ready_a), 32'd1);
      exp_q.push_back(burst[i]);
      tick();
    end
    dv_a = 1'b0;
    check_eq("burst_overflow", 32'(overflow_a), 32'd0);
    check_eq("burst_full",     32'(in_ready_a), 32'd0);
    wait_frames(base + 5, 120);
    for (int i = 1; i < 5; i++)
      check_eq("b2b_period", (starts_q.size() == 5) ? starts_q[i] - starts_q[i-1] : -1, 12);

    // Overflow while full during a frame
    repeat (3) tick();
    base = frames;
    pkt_a = 10'h0F0; dv_a = 1'b1; exp_q.push_back(10'h0F0);
    tick();
    dv_a = 1'b0;
    tick();
    pkt_a = 10'h111; dv_a = 1'b1; exp_q.push_back(10'h111); tick();
    pkt_a = 10'h222; exp_q.push_back(10'h222); tick();
    pkt_a = 10'h333; exp_q.push_back(10'h333); tick();
    pkt_a = 10'h0AB; exp_q.push_back(10'h0AB); tick();
    for (int k = 0; k < 3; k++) begin
      pkt_a = 10'h3C0 + 10'(k);
      check_eq("full_in_ready", 32'(in_ready_a), 32'd0);
      tick();
      check_eq("overflow_pulse", 32'(overflow_a), 32'd1);
    end
    dv_a = 1'b0;
    tick();
    check_eq("overflow_clear", 32'(overflow_a), 32'd0);
    wait_frames(base + 5, 150);

    // Idle gap of 3 on the second instance
    repeat (3) tick();
    starts_q.delete();
    base = frames;
    check_eq("gap_in_ready", 32'(in_ready_b), 32'd1);
    pkt_b = 10'h1E1; dv_b = 1'b1; exp_q.push_back(10'h1E1); tick();
    pkt_b = 10'h2D2; exp_q.push_back(10'h2D2); tick();
    dv_b = 1'b0;
    wait_frames(base + 2, 80);
    check_eq("gap_period", (starts_q.size() == 2) ? starts_q[1] - starts_q[0] : -1, 15);

    // Reset during data bit 5 with two packets queued
    repeat (3) tick();
    base = frames;
    pkt_a = 10'h3A5; dv_a = 1'b1; tick();
    pkt_a = 10'h05A; tick();
    pkt_a = 10'h2F0; tick();
    dv_a = 1'b0;
    repeat (4) tick();
    check_eq("busy_before_rst", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("midrst_sout",     32'(sout_a),     32'd1);
    check_eq("midrst_busy",     32'(busy_a),     32'd0);
    check_eq("midrst_in_ready", 32'(in_ready_a), 32'd1);
    check_eq("midrst_overflow", 32'(overflow_a), 32'd0);
    exp_q.delete();
    #2 rst = 1'b0;
    repeat (40) begin
      tick();
      check_eq("post_rst_idle", 32'(sout_a), 32'd1);
    end
    check_eq("no_frames_after_rst", frames, base);
    pkt_a = 10'h0C3; dv_a = 1'b1; exp_q.push_back(10'h0C3);
    tick();
    dv_a = 1'b0;
    wait_frames(base + 1, 50);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
